fetch_stage: RTL and testbench

IF-stage fetch unit for the RV32I 5-stage pipeline. It owns the PC, drives the instruction-memory read handshake, and buffers fetched instructions in a 2-entry queue. It presents {instr, pc, valid} to the IF/ID pipeline register. Control-flow redirects from EX flush the queue and discard any in-flight instruction-memory response.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_queue.sv | 46 ++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned QDEPTH = 2;
  localparam int unsigned CNT_W  = 2;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_stage_queue.sv
// Two-entry FIFO of fetched {instr, pc} packets; entry 0 is always the head.
module fetch_stage_queue
  import fetch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_pkt_t       i_data,
  output fetch_pkt_t       o_head,
  output logic [CNT_W-1:0] o_count
);

  fetch_pkt_t       r_q0;
  fetch_pkt_t       r_q1;
  logic [CNT_W-1:0] r_count;

  // Storage and occupancy; flush only clears the count, stale data is never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0    <= '0;
      r_q1    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_push && i_pop) begin
      r_q0 <= (r_count == CNT_W'(1)) ? i_data : r_q1;
      r_q1 <= i_data;
    end else if (i_push) begin
      if (r_count == CNT_W'(0)) begin
        r_q0 <= i_data;
      end else begin
        r_q1 <= i_data;
      end
      r_count <= r_count + CNT_W'(1);
    end else if (i_pop) begin
      r_q0    <= r_q1;
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_head  = r_q0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the imem read handshake, buffers two fetched words.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0060,
  parameter logic [XLEN-1:0] NOP_INSTR = RV32I_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_in,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            valid_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_next;
  logic [XLEN-1:0]  r_req_addr;
  logic [XLEN-1:0]  w_req_addr_next;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic             w_can_issue;
  fetch_pkt_t       w_push_pkt;
  fetch_pkt_t       w_head;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_next;

  // Queue bookkeeping; a redirect flushes and blocks both push and pop.
  assign w_valid      = (w_count != CNT_W'(0));
  assign w_pop        = w_valid && !stall_in && !redirect_valid;
  assign w_push       = (r_state == BUSY) && imem_resp && !redirect_valid;
  assign w_count_next = redirect_valid ? CNT_W'(0)
                                       : w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_can_issue  = (w_count_next < CNT_W'(QDEPTH));
  assign w_push_pkt   = '{instr: imem_rdata, pc: r_req_addr};

  fetch_stage_queue u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_push_pkt),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // State, PC and request-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
    end
  end

  // Next-state logic: single outstanding request; DROP swallows a response made stale by a redirect.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_req_addr_next = r_req_addr;
    case (r_state)
      IDLE: begin
        if (redirect_valid) begin
          w_pc_next = redirect_pc;
        end else if (w_can_issue) begin
          w_req_addr_next = r_pc;
          w_pc_next       = r_pc + XLEN'(4);
          w_state_next    = BUSY;
        end
      end
      BUSY: begin
        if (imem_resp) begin
          if (redirect_valid) begin
            w_pc_next    = redirect_pc;
            w_state_next = IDLE;
          end else if (w_can_issue) begin
            w_req_addr_next = r_pc;
            w_pc_next       = r_pc + XLEN'(4);
          end else begin
            w_state_next = IDLE;
          end
        end else if (redirect_valid) begin
          w_pc_next    = redirect_pc;
          w_state_next = DROP;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          w_pc_next = redirect_pc;
        end
        if (imem_resp) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decode directly from registered state and queue contents.
  assign imem_read = (r_state == BUSY) || (r_state == DROP);
  assign imem_addr = r_req_addr;
  assign valid_out = w_valid;
  assign instr_out = w_valid ? w_head.instr : NOP_INSTR;
  assign pc_out    = w_valid ? w_head.pc : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory and a pop scoreboard.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int          lat = 1;
  logic        m_pending = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cnt = 0;
  logic        forbid_en = 1'b0;
  logic [31:0] forbid_pc = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_read      (imem_read),
    .imem_addr      (imem_addr),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .valid_out      (valid_out),
    .instr_out      (instr_out),
    .pc_out         (pc_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Memory: accepts one request, answers after 'lat' cycles with a one-cycle resp pulse.
  always @(posedge clk) begin
    #1;
    imem_resp = 1'b0;
    if (!m_pending && imem_read) begin
      m_pending = 1'b1;
      m_addr    = imem_addr;
      m_cnt     = lat;
    end
    if (m_pending) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(m_addr);
        m_pending  = 1'b0;
      end
    end
  end

  // Monitors: request-address stability, forbidden PC, and scoreboard compare on every pop.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (rst_n && imem_read && m_pending)
      chk32("addr_stable", imem_addr, m_addr);
    if (forbid_en && valid_out)
      chk1("dropped_pc_seen", pc_out == forbid_pc, 1'b0);
    if (rst_n && valid_out && !stall_in && !redirect_valid && sb.size() > 0) begin
      exp_pc = sb.pop_front();
      chk32("pop_pc", pc_out, exp_pc);
      chk32("pop_instr", instr_out, mem_word(exp_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    forbid_en      = 1'b0;
    repeat (5) step();
  endtask

  task automatic wait_sb_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk32("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_mem(input logic [31:0] a, input logic want_resp, input int budget);
    int   n = 0;
    logic hit;
    hit = (m_addr == a) && (want_resp ? imem_resp : m_pending);
    while (!hit && n < budget) begin
      step();
      n++;
      hit = (m_addr == a) && (want_resp ? imem_resp : m_pending);
    end
    chk1("wait_mem", hit, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) step();
    chk1 ("rst_imem_read", imem_read, 1'b0);
    chk1 ("rst_valid", valid_out, 1'b0);
    chk32("rst_instr", instr_out, RV32I_NOP);
    chk32("rst_pc_out", pc_out, 32'd0);
    chk32("rst_imem_addr", imem_addr, 32'd0);

    // 1: back-to-back fetch with 1-cycle memory
    lat = 1;
    sb.push_back(32'h60); sb.push_back(32'h64); sb.push_back(32'h68);
    rst_n = 1'b1;
    step();
    chk1 ("t1_read", imem_read, 1'b1);
    chk32("t1_addr0", imem_addr, 32'h60);
    chk1 ("t1_valid0", valid_out, 1'b0);
    step();
    chk32("t1_addr1", imem_addr, 32'h64);
    chk1 ("t1_valid1", valid_out, 1'b1);
    step();
    chk32("t1_addr2", imem_addr, 32'h68);
    wait_sb_empty(10);

    // 2: stall fills queue, then drains in order
    do_reset();
    lat = 1; stall_in = 1'b1;
    sb.push_back(32'h60); sb.push_back(32'h64); sb.push_back(32'h68);
    rst_n = 1'b1;
    repeat (3) step();
    chk1 ("t2_read_off", imem_read, 1'b0);
    chk1 ("t2_valid", valid_out, 1'b1);
    chk32("t2_head", pc_out, 32'h60);
    repeat (3) step();
    chk1 ("t2_still_off", imem_read, 1'b0);
    stall_in = 1'b0;
    step();
    chk1 ("t2_refetch_read", imem_read, 1'b1);
    chk32("t2_refetch_addr", imem_addr, 32'h68);
    wait_sb_empty(10);

    // 3: redirect while 0x64 outstanding on a 3-cycle memory
    do_reset();
    lat = 3; forbid_en = 1'b1; forbid_pc = 32'h64;
    sb.push_back(32'h60); sb.push_back(32'h200);
    rst_n = 1'b1;
    wait_mem(32'h64, 1'b0, 20);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk1 ("t3_drop_read", imem_read, 1'b1);
    chk32("t3_drop_addr", imem_addr, 32'h64);
    wait_mem(32'h64, 1'b1, 10);
    step();
    chk1 ("t3_idle_read", imem_read, 1'b0);
    chk1 ("t3_idle_valid", valid_out, 1'b0);
    step();
    chk1 ("t3_new_read", imem_read, 1'b1);
    chk32("t3_new_addr", imem_addr, 32'h200);
    wait_sb_empty(20);
    forbid_en = 1'b0;

    // 4: redirect coincident with the response for 0x68
    do_reset();
    lat = 3; forbid_en = 1'b1; forbid_pc = 32'h68;
    sb.push_back(32'h60); sb.push_back(32'h64); sb.push_back(32'h300);
    rst_n = 1'b1;
    wait_mem(32'h68, 1'b1, 40);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk1 ("t4_empty", valid_out, 1'b0);
    chk1 ("t4_idle_read", imem_read, 1'b0);
    chk32("t4_nop", instr_out, RV32I_NOP);
    step();
    chk1 ("t4_new_read", imem_read, 1'b1);
    chk32("t4_new_addr", imem_addr, 32'h300);
    wait_sb_empty(20);
    forbid_en = 1'b0;

    // 5: redirect with a full, stalled queue
    do_reset();
    lat = 1; stall_in = 1'b1;
    rst_n = 1'b1;
    repeat (4) step();
    chk1 ("t5_full_valid", valid_out, 1'b1);
    chk1 ("t5_full_read", imem_read, 1'b0);
    chk32("t5_full_head", pc_out, 32'h60);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    chk1 ("t5_flush_valid", valid_out, 1'b0);
    chk32("t5_flush_instr", instr_out, RV32I_NOP);
    chk32("t5_flush_pc", pc_out, 32'd0);
    chk1 ("t5_flush_read", imem_read, 1'b0);
    step();
    chk1 ("t5_new_read", imem_read, 1'b1);
    chk32("t5_new_addr", imem_addr, 32'h400);
    sb.push_back(32'h400);
    stall_in = 1'b0;
    wait_sb_empty(10);

    // 6: async reset mid-request, late response lands during reset
    do_reset();
    lat = 3; stall_in = 1'b1;
    rst_n = 1'b1;
    wait_mem(32'h64, 1'b0, 20);
    chk1("t6_pre_valid", valid_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t6_async_read", imem_read, 1'b0);
    chk1("t6_async_valid", valid_out, 1'b0);
    stall_in = 1'b0;
    repeat (4) step();
    sb.push_back(32'h60); sb.push_back(32'h64);
    rst_n = 1'b1;
    step();
    chk1 ("t6_restart_read", imem_read, 1'b1);
    chk32("t6_restart_addr", imem_addr, 32'h60);
    wait_sb_empty(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
